// File: rtl/rr_logging_merge_n_pkg.sv
// Shared definitions for the logging-stream merger: timestamp width, tag-width
// helper and the round-robin next-grant search used by arbiters in this family.
package rr_logging_pkg;

  localparam int RR_TS_W     = 32;
  localparam int RR_MAX_CH   = 16;
  localparam int RR_MAX_ID_W = 4;

  function automatic int rr_id_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  // First requester strictly after 'last', wrapping modulo num_ch; returns 'last' if none.
  function automatic logic [RR_MAX_ID_W-1:0] rr_next_grant(
    input logic [RR_MAX_CH-1:0]   req,
    input logic [RR_MAX_ID_W-1:0] last,
    input int                     num_ch
  );
    logic [RR_MAX_ID_W-1:0] grant;
    logic                   found;
    int                     idx;
    grant = last;
    found = 1'b0;
    for (int i = 1; i <= RR_MAX_CH; i++) begin
      if (i <= num_ch) begin
        idx = (int'(last) + i) % num_ch;
        if (!found && req[RR_MAX_ID_W'(idx)]) begin
          grant = RR_MAX_ID_W'(idx);
          found = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rr_logging_merge_n_if.sv
// Channel-side and output-side bundle of the merger. out_ts exists only when
// RR_MERGE_TIMESTAMP_EN is defined.
interface rr_logging_merge_n_if
  import rr_logging_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 64,
  parameter int ID_W   = rr_id_w(NUM_CH)
);
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [ID_W-1:0]          out_ch;
  logic                     out_ready;
  logic                     idle;
`ifdef RR_MERGE_TIMESTAMP_EN
  logic [RR_TS_W-1:0]       out_ts;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_ch, idle, out_ts);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_ch, idle, out_ts);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_ch, idle);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_ch, idle);
`endif
endinterface

// File: rtl/rr_logging_merge_n_arb.sv
// Combinational round-robin arbiter: picks the first requester after the
// last grant; the last-grant register lives in the parent.
module rr_round_robin_arbiter
  import rr_logging_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int ID_W   = rr_id_w(NUM_CH)
)(
  input  logic [NUM_CH-1:0] i_req,
  input  logic [ID_W-1:0]   i_last,
  output logic [NUM_CH-1:0] o_grant,
  output logic [ID_W-1:0]   o_grant_id,
  output logic              o_any
);

  logic [RR_MAX_CH-1:0]   w_req_ext;
  logic [RR_MAX_ID_W-1:0] w_id_ext;

  // Widen to the package search width, then decode the winner one-hot.
  always_comb begin
    w_req_ext             = '0;
    w_req_ext[NUM_CH-1:0] = i_req;
    w_id_ext              = rr_next_grant(w_req_ext, RR_MAX_ID_W'(i_last), NUM_CH);
    o_any                 = |i_req;
    o_grant_id            = ID_W'(w_id_ext);
    for (int i = 0; i < NUM_CH; i++) begin
      o_grant[i] = o_any && (w_id_ext == RR_MAX_ID_W'(i));
    end
  end

endmodule

// File: rtl/rr_logging_merge_n.sv
// N-channel logging merger: per-channel FIFOs round-robin merged onto one tagged
// output register. Define RR_MERGE_TIMESTAMP_EN to add enqueue-cycle stamps (out_ts).
module rr_logging_merge_n
  import rr_logging_pkg::*;
#(
  parameter int  NUM_CH     = 5,
  parameter int  DATA_W     = 64,
  parameter int  FIFO_DEPTH = 4,
  localparam int ID_W       = rr_id_w(NUM_CH)
)(
  input  logic                 clk,
  input  logic                 rstn,
  rr_logging_merge_n_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic                 r_ready_en;
  logic [PW-1:0]        r_wr_ptr [NUM_CH];
  logic [PW-1:0]        r_rd_ptr [NUM_CH];
  logic [DATA_W-1:0]    r_mem    [NUM_CH][FIFO_DEPTH];
  logic [ID_W-1:0]      r_last_grant;
  logic                 r_out_valid;
  logic [DATA_W-1:0]    r_out_data;
  logic [ID_W-1:0]      r_out_ch;
  logic                 r_idle;

  logic [NUM_CH-1:0]    w_empty;
  logic [NUM_CH-1:0]    w_full;
  logic [NUM_CH-1:0]    w_push;
  logic [NUM_CH-1:0]    w_pop;
  logic [NUM_CH-1:0]    w_grant;
  logic [ID_W-1:0]      w_grant_id;
  logic                 w_any;
  logic                 w_load;
  logic [DATA_W-1:0]    w_head_data;
  logic                 w_next_empty_all;
  logic                 w_next_valid;
  logic                 w_next_idle;

`ifdef RR_MERGE_TIMESTAMP_EN
  logic [RR_TS_W-1:0]   r_ts_cnt;
  logic [RR_TS_W-1:0]   r_ts_mem [NUM_CH][FIFO_DEPTH];
  logic [RR_TS_W-1:0]   r_out_ts;
  logic [RR_TS_W-1:0]   w_head_ts;
`endif

  assign w_load        = !r_out_valid || bus.out_ready;
  assign bus.in_ready  = {NUM_CH{r_ready_en}} & ~w_full;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.idle      = r_idle;

  // FIFO status; the wrap bit separates full from empty. Full never accepts, even when popping.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_empty[i] = (r_wr_ptr[i] == r_rd_ptr[i]);
      w_full[i]  = (r_wr_ptr[i][AW] != r_rd_ptr[i][AW]) &&
                   (r_wr_ptr[i][AW-1:0] == r_rd_ptr[i][AW-1:0]);
      w_push[i]  = bus.in_valid[i] && r_ready_en && !w_full[i];
    end
  end

  rr_round_robin_arbiter #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_arb (
    .i_req      (~w_empty),
    .i_last     (r_last_grant),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id),
    .o_any      (w_any)
  );

  // Pop the winner and mux its head entry.
  always_comb begin
    w_head_data = '0;
`ifdef RR_MERGE_TIMESTAMP_EN
    w_head_ts   = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      w_pop[i]    = w_load && w_grant[i];
      w_head_data = w_head_data | ({DATA_W{w_grant[i]}} & r_mem[i][r_rd_ptr[i][AW-1:0]]);
`ifdef RR_MERGE_TIMESTAMP_EN
      w_head_ts   = w_head_ts | ({RR_TS_W{w_grant[i]}} & r_ts_mem[i][r_rd_ptr[i][AW-1:0]]);
`endif
    end
  end

  // idle is computed from next-state so it lines up with the state it describes.
  always_comb begin
    w_next_empty_all = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      w_next_empty_all = w_next_empty_all &&
        ((r_wr_ptr[i] + PW'(w_push[i])) == (r_rd_ptr[i] + PW'(w_pop[i])));
    end
    w_next_valid = w_load ? w_any : r_out_valid;
    w_next_idle  = w_next_empty_all && !w_next_valid;
  end

  // Entry storage; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wr_ptr[i][AW-1:0]] <= bus.in_data[i*DATA_W +: DATA_W];
`ifdef RR_MERGE_TIMESTAMP_EN
        r_ts_mem[i][r_wr_ptr[i][AW-1:0]] <= r_ts_cnt;
`endif
      end
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_wr_ptr[i] <= r_wr_ptr[i] + PW'(w_push[i]);
        r_rd_ptr[i] <= r_rd_ptr[i] + PW'(w_pop[i]);
      end
    end
  end

  // Output register, last grant, ready enable and idle flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ready_en   <= 1'b0;
      r_idle       <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ch     <= '0;
      r_last_grant <= ID_W'(NUM_CH - 1);
    end else begin
      r_ready_en <= 1'b1;
      r_idle     <= w_next_idle;
      if (w_load) begin
        r_out_valid <= w_any;
        if (w_any) begin
          r_out_data   <= w_head_data;
          r_out_ch     <= w_grant_id;
          r_last_grant <= w_grant_id;
        end
      end
    end
  end

`ifdef RR_MERGE_TIMESTAMP_EN
  assign bus.out_ts = r_out_ts;

  // Free-running cycle counter and the stamp travelling with the output entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ts_cnt <= '0;
      r_out_ts <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 32'd1;
      if (w_load && w_any) begin
        r_out_ts <= w_head_ts;
      end
    end
  end
`endif

endmodule
